mem_ctrl: RTL

- Arbitrates the single byte-wide RAM/IO port between instruction fetch (IF, word reads) and the load/store buffer (LSB, 1/2/4-byte loads and stores).
- Performs byte-serial little-endian transfers and returns zero-extended data; the LSB applies sign extension.
- Sits directly downstream of the LSB's memory request interface and the IF unit, and directly upstream of the external RAM/IO bus.

---
 rtl/mem_ctrl_pkg.sv | 48 ++++
 rtl/mem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, encodings and state definitions for the byte-serial
// memory controller.
package mem_ctrl_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;
    localparam int BYTE_W   = 8;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;

    localparam logic [2:0] LEN_B = 3'b001;
    localparam logic [2:0] LEN_H = 3'b010;
    localparam logic [2:0] LEN_W = 3'b100;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    localparam int IO_SEL_HI_DEF = 17;
    localparam int IO_SEL_LO_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSB
    } owner_e;

    // Anything that is not a clean one-hot length moves a full word.
    function automatic logic [2:0] len_bytes(input logic [2:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            LEN_W:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter between instruction fetch and the load/store buffer
// on the single byte-wide RAM/IO port.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int IO_SEL_HI = IO_SEL_HI_DEF,
    parameter int IO_SEL_LO = IO_SEL_LO_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clr,

    input  logic                IF_S,
    input  logic [ADDR_BUS-1:0] IF_pc,
    output logic                IF_success,
    output logic [DATA_BUS-1:0] IF_value,

    input  logic                LSB_S,
    input  logic                LSB_op,
    input  logic [ADDR_BUS-1:0] LSB_pc,
    input  logic [2:0]          LSB_len,
    input  logic [DATA_BUS-1:0] LSB_data,
    output logic                LSB_success,
    output logic [DATA_BUS-1:0] LSB_value,

    input  logic [BYTE_W-1:0]   mem_din,
    output logic [BYTE_W-1:0]   mem_dout,
    output logic [ADDR_BUS-1:0] mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [ADDR_BUS-1:0]   base_q, base_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_BUS-1:0]   wdata_q, wdata_d;
    logic [DATA_BUS-1:0]   result_q, result_d;
    logic [1:0]            din_idx_q, din_idx_d;
    logic                  din_vld_q, din_vld_d;

    logic                  if_success_q, if_success_d;
    logic                  lsb_success_q, lsb_success_d;
    logic [DATA_BUS-1:0]   if_value_q, if_value_d;
    logic [DATA_BUS-1:0]   lsb_value_q, lsb_value_d;
    logic [ADDR_BUS-1:0]   mem_a_q, mem_a_d;
    logic [BYTE_W-1:0]     mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;

    logic [2:0]            nxt_cnt;
    logic                  io_stall;
    logic [DATA_BUS-1:0]   result_cap;

    assign nxt_cnt  = cnt_q + 3'd1;
    assign io_stall = (&mem_a_q[IO_SEL_HI:IO_SEL_LO]) && io_buffer_full;

    // mem_din always answers last cycle's mem_a, even while rdy is low,
    // so capture runs every edge and is keyed by byte index, not by cycle.
    always_comb begin
        result_cap = result_q;
        if (din_vld_q) begin
            result_cap[{din_idx_q, 3'b000} +: BYTE_W] = mem_din;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        base_d        = base_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        result_d      = result_cap;
        din_vld_d     = (state_q == ST_READ) ? TRUE : FALSE;
        din_idx_d     = mem_a_q[1:0] - base_q[1:0];
        if_success_d  = if_success_q;
        lsb_success_d = lsb_success_q;
        if_value_d    = if_value_q;
        lsb_value_d   = lsb_value_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = mem_wr_q;

        if (rdy) begin
            if_success_d  = DISABLE;
            lsb_success_d = DISABLE;

            unique case (state_q)
                ST_IDLE: begin
                    if (!clr && (LSB_S || IF_S)) begin
                        cnt_d    = '0;
                        result_d = '0;
                        if (LSB_S) begin
                            owner_d    = OWN_LSB;
                            base_d     = LSB_pc;
                            len_d      = len_bytes(LSB_len);
                            wdata_d    = LSB_data;
                            mem_a_d    = LSB_pc;
                            mem_dout_d = LSB_data[BYTE_W-1:0];
                        end else begin
                            owner_d = OWN_IF;
                            base_d  = IF_pc;
                            len_d   = len_bytes(LEN_W);
                            mem_a_d = IF_pc;
                        end
                        if (LSB_S && LSB_op == OP_STORE) begin
                            state_d  = ST_WRITE;
                            mem_wr_d = ENABLE;
                        end else begin
                            state_d  = ST_READ;
                            mem_wr_d = DISABLE;
                        end
                    end
                end

                ST_READ: begin
                    if (clr) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        if (owner_q == OWN_LSB) begin
                            lsb_success_d = ENABLE;
                            lsb_value_d   = result_cap;
                        end else begin
                            if_success_d = ENABLE;
                            if_value_d   = result_cap;
                        end
                    end else begin
                        cnt_d = nxt_cnt;
                        if (nxt_cnt < len_q) begin
                            mem_a_d = base_q + {29'd0, nxt_cnt};
                        end
                    end
                end

                // Committed stores finish even across a flush.
                ST_WRITE: begin
                    if (!io_stall) begin
                        if (nxt_cnt < len_q) begin
                            cnt_d      = nxt_cnt;
                            mem_a_d    = base_q + {29'd0, nxt_cnt};
                            mem_dout_d = wdata_q[{nxt_cnt[1:0], 3'b000} +: BYTE_W];
                        end else begin
                            state_d       = ST_DONE;
                            cnt_d         = '0;
                            mem_wr_d      = DISABLE;
                            lsb_success_d = ENABLE;
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_IF;
            base_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            wdata_q       <= '0;
            result_q      <= '0;
            din_idx_q     <= '0;
            din_vld_q     <= FALSE;
            if_success_q  <= DISABLE;
            lsb_success_q <= DISABLE;
            if_value_q    <= '0;
            lsb_value_q   <= '0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= DISABLE;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            base_q        <= base_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            wdata_q       <= wdata_d;
            result_q      <= result_d;
            din_idx_q     <= din_idx_d;
            din_vld_q     <= din_vld_d;
            if_success_q  <= if_success_d;
            lsb_success_q <= lsb_success_d;
            if_value_q    <= if_value_d;
            lsb_value_q   <= lsb_value_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
        end
    end

    // A frozen DONE keeps its pulse pending until rdy returns.
    assign IF_success  = if_success_q & rdy;
    assign LSB_success = lsb_success_q & rdy;
    assign IF_value    = if_value_q;
    assign LSB_value   = lsb_value_q;
    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign mem_wr      = mem_wr_q & rdy & ~io_stall;

endmodule
